// File: rtl/fifo_flags.sv
// Parametrised show-ahead synchronous FIFO with occupancy count, threshold flags,
// sticky overflow/underflow and synchronous flush. Define FIFO_WR_EDGE_EN for edge-qualified writes.
module fifo_flags #(
    parameter int unsigned NB_WORD         = 8,
    parameter int unsigned N_WORD_BUFFER   = 16,
    parameter int unsigned ALMOST_FULL_TH  = 12,
    parameter int unsigned ALMOST_EMPTY_TH = 4
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [NB_WORD-1:0]                   i_data,
    input  logic                                 i_write,
    input  logic                                 i_read,
    input  logic                                 i_clear,
    output logic [NB_WORD-1:0]                   o_data,
    output logic                                 o_fifo_empty,
    output logic                                 o_fifo_full,
    output logic                                 o_almost_empty,
    output logic                                 o_almost_full,
    output logic [$clog2(N_WORD_BUFFER+1)-1:0]   o_count,
    output logic                                 o_overflow,
    output logic                                 o_underflow
);

    localparam int unsigned NB_PTR   = $clog2(N_WORD_BUFFER);
    localparam int unsigned NB_COUNT = $clog2(N_WORD_BUFFER + 1);

    localparam logic [NB_PTR-1:0]   PTR_LAST  = NB_PTR'(N_WORD_BUFFER - 1);
    localparam logic [NB_COUNT-1:0] COUNT_MAX = NB_COUNT'(N_WORD_BUFFER);
    localparam logic [NB_COUNT-1:0] AF_TH     = NB_COUNT'(ALMOST_FULL_TH);
    localparam logic [NB_COUNT-1:0] AE_TH     = NB_COUNT'(ALMOST_EMPTY_TH);

    if (NB_WORD < 1) begin : g_chk_width
        $error("fifo_flags: NB_WORD must be at least 1");
    end
    if (N_WORD_BUFFER < 2) begin : g_chk_depth
        $error("fifo_flags: N_WORD_BUFFER must be at least 2");
    end
    if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > N_WORD_BUFFER) begin : g_chk_af
        $error("fifo_flags: ALMOST_FULL_TH must lie in 1..N_WORD_BUFFER");
    end
    if (ALMOST_EMPTY_TH > N_WORD_BUFFER - 1) begin : g_chk_ae
        $error("fifo_flags: ALMOST_EMPTY_TH must lie in 0..N_WORD_BUFFER-1");
    end

    logic [NB_WORD-1:0]  mem_q [N_WORD_BUFFER];
    logic [NB_PTR-1:0]   rd_ptr_q, rd_ptr_d;
    logic [NB_PTR-1:0]   wr_ptr_q, wr_ptr_d;
    logic [NB_COUNT-1:0] count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic empty, full;
    logic wr_q, wr_acc, rd_acc, mem_we;

`ifdef FIFO_WR_EDGE_EN
    logic write_d_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            write_d_q <= 1'b0;
        end else begin
            write_d_q <= i_write;
        end
    end

    // Rising-edge detect so a held strobe from the UART writes only once.
    assign wr_q = i_write & ~write_d_q;
`else
    assign wr_q = i_write;
`endif

    assign empty = (count_q == '0);
    assign full  = (count_q == COUNT_MAX);

    // A read frees the slot a write needs when full, so both are accepted together.
    assign rd_acc = i_read & ~empty;
    assign wr_acc = wr_q & (~full | rd_acc);
    assign mem_we = wr_acc & ~i_clear;

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (i_clear) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (rd_acc) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + NB_PTR'(1);
            end
            if (wr_acc) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + NB_PTR'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + NB_COUNT'(1);
                2'b01:   count_d = count_q - NB_COUNT'(1);
                default: count_d = count_q;
            endcase
            if (wr_q && !wr_acc) begin
                overflow_d = 1'b1;
            end
            if (i_read && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; flush and reset only move pointers.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_data         = mem_q[rd_ptr_q];
    assign o_fifo_empty   = empty;
    assign o_fifo_full    = full;
    assign o_almost_empty = (count_q <= AE_TH);
    assign o_almost_full  = (count_q >= AF_TH);
    assign o_count        = count_q;
    assign o_overflow     = overflow_q;
    assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_flags.sv
// Directed bench for fifo_flags at depth 6, thresholds 5/1; covers FIFO_WR_EDGE_EN when defined.
module tb_fifo_flags;

    localparam int unsigned NB_WORD = 8;
    localparam int unsigned DEPTH   = 6;
    localparam int unsigned AF_TH   = 5;
    localparam int unsigned AE_TH   = 1;
    localparam int unsigned NB_CNT  = $clog2(DEPTH + 1);

    logic               clk;
    logic               rst;
    logic [NB_WORD-1:0] data_in;
    logic               write;
    logic               read;
    logic               clear;
    logic [NB_WORD-1:0] data_out;
    logic               empty, full, aempty, afull;
    logic [NB_CNT-1:0]  count;
    logic               ovf, unf;

    int checks = 0;
    int errors = 0;

    fifo_flags #(
        .NB_WORD        (NB_WORD),
        .N_WORD_BUFFER  (DEPTH),
        .ALMOST_FULL_TH (AF_TH),
        .ALMOST_EMPTY_TH(AE_TH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_data        (data_in),
        .i_write       (write),
        .i_read        (read),
        .i_clear       (clear),
        .o_data        (data_out),
        .o_fifo_empty  (empty),
        .o_fifo_full   (full),
        .o_almost_empty(aempty),
        .o_almost_full (afull),
        .o_count       (count),
        .o_overflow    (ovf),
        .o_underflow   (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, " count"}, 32'(count), 32'd0);
        check_val({tag, " empty"}, 32'(empty), 32'd1);
        check_val({tag, " aempty"}, 32'(aempty), 32'd1);
        check_val({tag, " full"}, 32'(full), 32'd0);
        check_val({tag, " afull"}, 32'(afull), 32'd0);
        check_val({tag, " ovf"}, 32'(ovf), 32'd0);
        check_val({tag, " unf"}, 32'(unf), 32'd0);
    endtask

    initial begin
        rst     = 1'b0;
        data_in = '0;
        write   = 1'b0;
        read    = 1'b0;
        clear   = 1'b0;
        #12;
        check_reset_state("reset");
        #5;
        rst = 1'b1;
        step();

`ifndef FIFO_WR_EDGE_EN
        // Fill to full, watching threshold transitions.
        for (int i = 0; i < 6; i++) begin
            write   = 1'b1;
            data_in = 8'(8'h11 + i);
            step();
            check_val("fill count", 32'(count), 32'(i + 1));
            check_val("fill aempty", 32'(aempty), 32'((i + 1) <= 1));
            check_val("fill afull", 32'(afull), 32'((i + 1) >= 5));
            check_val("fill full", 32'(full), 32'((i + 1) == 6));
            check_val("fill head", 32'(data_out), 32'h11);
        end

        data_in = 8'h77;
        step();
        write = 1'b0;
        check_val("ovf set", 32'(ovf), 32'd1);
        check_val("ovf count", 32'(count), 32'd6);

        for (int i = 0; i < 6; i++) begin
            check_val("drain head", 32'(data_out), 32'(8'h11 + i));
            read = 1'b1;
            step();
        end
        read = 1'b0;
        check_val("drain empty", 32'(empty), 32'd1);
        check_val("drain count", 32'(count), 32'd0);
        check_val("drain unf", 32'(unf), 32'd0);

        // Prime with three words, then stream through the wrap point.
        for (int i = 0; i < 3; i++) begin
            write   = 1'b1;
            data_in = 8'(8'h20 + i);
            step();
        end
        for (int k = 0; k < 20; k++) begin
            check_val("wrap head", 32'(data_out), 32'(8'h20 + k));
            write   = 1'b1;
            read    = 1'b1;
            data_in = 8'(8'h23 + k);
            step();
            check_val("wrap count", 32'(count), 32'd3);
        end
        write = 1'b0;
        read  = 1'b0;

        // Contents 0x34..0x36; top up to full with 0x37..0x39.
        for (int i = 0; i < 3; i++) begin
            write   = 1'b1;
            data_in = 8'(8'h37 + i);
            step();
        end
        check_val("refill full", 32'(full), 32'd1);
        check_val("refill head", 32'(data_out), 32'h34);
        read    = 1'b1;
        data_in = 8'hAA;
        step();
        write = 1'b0;
        read  = 1'b0;
        check_val("full rw count", 32'(count), 32'd6);
        check_val("full rw full", 32'(full), 32'd1);
        check_val("full rw head", 32'(data_out), 32'h35);
        for (int i = 0; i < 5; i++) begin
            check_val("post rw head", 32'(data_out), 32'(8'h35 + i));
            read = 1'b1;
            step();
        end
        read = 1'b0;
        check_val("aa head", 32'(data_out), 32'hAA);
        check_val("aa count", 32'(count), 32'd1);
        read = 1'b1;
        step();
        read = 1'b0;
        check_val("aa drained", 32'(empty), 32'd1);

        write   = 1'b1;
        read    = 1'b1;
        data_in = 8'h5C;
        step();
        write = 1'b0;
        read  = 1'b0;
        check_val("empty rw unf", 32'(unf), 32'd1);
        check_val("empty rw count", 32'(count), 32'd1);
        check_val("empty rw head", 32'(data_out), 32'h5C);
        check_val("empty rw ovf", 32'(ovf), 32'd1);

        clear   = 1'b1;
        write   = 1'b1;
        data_in = 8'h99;
        step();
        clear = 1'b0;
        write = 1'b0;
        check_reset_state("clear");
        step();
        check_val("clear dropped", 32'(count), 32'd0);
`endif

        // Held write burst, then asynchronous reset between edges.
        write   = 1'b1;
        data_in = 8'h42;
        for (int i = 0; i < 4; i++) begin
            step();
        end
`ifdef FIFO_WR_EDGE_EN
        check_val("burst count", 32'(count), 32'd1);
        check_val("burst ovf", 32'(ovf), 32'd0);
        check_val("burst head", 32'(data_out), 32'h42);
`else
        check_val("burst count", 32'(count), 32'd4);
        check_val("burst afull", 32'(afull), 32'd0);
        check_val("burst head", 32'(data_out), 32'h42);
`endif
        #2;
        rst = 1'b0;
        #1;
        check_reset_state("async rst");
        write = 1'b0;
        #10;
        rst = 1'b1;
        step();
        check_val("post rst count", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
